// File: rtl/data_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : data_mem_responder                                           |
// | Description : Round-robin responder serving per-channel LSU read/write     |
// |               requests against an internal single-ported data memory.      |
// |               Optional macro DATA_MEM_BOUNDS_CHECK_EN adds range checking. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module data_mem_responder #(
  parameter int NUM_CHANNELS = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 8,
  parameter int MEM_DEPTH    = 256
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CHANNELS-1:0]            mem_read_valid,
  input  logic [NUM_CHANNELS*ADDR_WIDTH-1:0] mem_read_address,
  output logic [NUM_CHANNELS-1:0]            mem_read_ready,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0] mem_read_data,
  input  logic [NUM_CHANNELS-1:0]            mem_write_valid,
  input  logic [NUM_CHANNELS*ADDR_WIDTH-1:0] mem_write_address,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] mem_write_data,
  output logic [NUM_CHANNELS-1:0]            mem_write_ready,
  output logic                               busy,
  output logic                               addr_error
);

  localparam int c_CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int c_IDX_W = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_RESPOND = 2'd2
  } state_t;

  state_t                           r_state;
  state_t                           w_state_nxt;
  logic [c_CH_W-1:0]                r_rr_ptr;
  logic [c_CH_W-1:0]                r_chan;
  logic [c_CH_W-1:0]                w_grant;
  logic                             w_found;
  logic                             w_grant_wr;
  logic                             r_is_write;
  logic [ADDR_WIDTH-1:0]            r_addr;
  logic [DATA_WIDTH-1:0]            r_wdata;
  logic [NUM_CHANNELS*DATA_WIDTH-1:0] r_rdata;
  logic [DATA_WIDTH-1:0]            r_mem [MEM_DEPTH];
  logic [c_IDX_W-1:0]               w_idx;
  logic                             w_in_range;
  logic [NUM_CHANNELS-1:0]          w_req;

  assign w_req         = mem_read_valid | mem_write_valid;
  assign w_idx         = r_addr[c_IDX_W-1:0];
  assign mem_read_data = r_rdata;

  // First requesting channel at or after the round-robin pointer, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      if (!w_found && w_req[(int'(r_rr_ptr) + k) % NUM_CHANNELS]) begin
        w_found = 1'b1;
        w_grant = c_CH_W'((int'(r_rr_ptr) + k) % NUM_CHANNELS);
      end
    end
  end

  assign w_grant_wr = mem_write_valid[w_grant];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt     = r_state;
    mem_read_ready  = '0;
    mem_write_ready = '0;
    busy            = (r_state != S_IDLE);
    case (r_state)
      S_IDLE:   if (w_found) w_state_nxt = S_ACCESS;
      S_ACCESS: w_state_nxt = S_RESPOND;
      S_RESPOND: begin
        w_state_nxt = S_IDLE;
        if (r_is_write) mem_write_ready[r_chan] = 1'b1;
        else            mem_read_ready[r_chan]  = 1'b1;
      end
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr_ptr   <= '0;
      r_chan     <= '0;
      r_is_write <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_chan     <= w_grant;
            r_is_write <= w_grant_wr;
            r_addr     <= w_grant_wr ? mem_write_address[w_grant*ADDR_WIDTH +: ADDR_WIDTH]
                                     : mem_read_address[w_grant*ADDR_WIDTH +: ADDR_WIDTH];
            r_wdata    <= mem_write_data[w_grant*DATA_WIDTH +: DATA_WIDTH];
          end
        end
        S_ACCESS: begin
          if (!r_is_write)
            r_rdata[r_chan*DATA_WIDTH +: DATA_WIDTH] <= w_in_range ? r_mem[w_idx] : '0;
        end
        S_RESPOND: r_rr_ptr <= c_CH_W'((int'(r_chan) + 1) % NUM_CHANNELS);
        default: ;
      endcase
    end
  end

  // Array is deliberately left without reset; a reset before the ACCESS edge
  // returns the FSM to IDLE, so the pending write never commits.
  always_ff @(posedge clk) begin
    if (r_state == S_ACCESS && r_is_write && w_in_range)
      r_mem[w_idx] <= r_wdata;
  end

`ifdef DATA_MEM_BOUNDS_CHECK_EN
  logic r_addr_error;

  assign w_in_range = ((r_addr >> c_IDX_W) == '0);
  assign addr_error = r_addr_error;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                    r_addr_error <= 1'b0;
    else if (r_state == S_ACCESS && !w_in_range)  r_addr_error <= 1'b1;
  end
`else
  logic w_unused_addr;

  // Upper address bits are discarded: accesses wrap onto the array.
  assign w_unused_addr = ^r_addr;
  assign w_in_range    = 1'b1;
  assign addr_error    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// Testbench for data_mem_responder: per-channel request queues, a request-level
// round-robin reference model, and a scoreboard monitor on the ready pulses.
module tb_data_mem_responder;
  localparam int NC = 4;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int MD = 128;
  localparam int QD = 64;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [NC-1:0]    mem_read_valid = '0;
  logic [NC*AW-1:0] mem_read_address = '0;
  logic [NC-1:0]    mem_read_ready;
  logic [NC*DW-1:0] mem_read_data;
  logic [NC-1:0]    mem_write_valid = '0;
  logic [NC*AW-1:0] mem_write_address = '0;
  logic [NC*DW-1:0] mem_write_data = '0;
  logic [NC-1:0]    mem_write_ready;
  logic             busy;
  logic             addr_error;

  always #5 clk = ~clk;

  data_mem_responder #(.NUM_CHANNELS(NC), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(MD)) dut (
    .clk(clk), .reset(reset),
    .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
    .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
    .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready),
    .busy(busy), .addr_error(addr_error)
  );

  typedef struct {
    int          chan;
    bit          is_wr;
    logic [DW-1:0] data;
    int          cyc;
  } exp_t;

  exp_t          exp_q[$];
  int            n_vec = 0;
  int            n_bad = 0;
  int            cyc = 0;
  logic [DW-1:0] mm [MD];
  logic [DW-1:0] last_rd [NC];
  bit            m_err;
  int            m_ptr;
  logic [AW-1:0] wa [NC][QD];
  logic [DW-1:0] wd [NC][QD];
  logic [AW-1:0] ra [NC][QD];
  int            wh [NC], wt [NC], rh [NC], rt [NC];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Scoreboard monitor: every ready pulse must match the next expected service.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset && ((|mem_read_ready) || (|mem_write_ready))) begin
      check("onehot_ready", $countones({mem_read_ready, mem_write_ready}), 1);
      if (exp_q.size() == 0) begin
        check("unexpected_ready", {mem_read_ready, mem_write_ready}, 0);
      end else begin
        e = exp_q.pop_front();
        check("ready_vec", {mem_read_ready, mem_write_ready},
              e.is_wr ? (64'(1) << e.chan) : (64'(1) << (e.chan + NC)));
        check("ready_cycle", cyc, e.cyc);
        if (!e.is_wr) check("read_data", mem_read_data[e.chan*DW +: DW], e.data);
      end
    end
  end

  function automatic bit oob(logic [AW-1:0] a);
`ifdef DATA_MEM_BOUNDS_CHECK_EN
    return int'(a) >= MD;
`else
    return 1'b0;
`endif
  endfunction

  function automatic void add_wr(int c, logic [AW-1:0] a, logic [DW-1:0] d);
    wa[c][wt[c]] = a;
    wd[c][wt[c]] = d;
    wt[c]++;
  endfunction

  function automatic void add_rd(int c, logic [AW-1:0] a);
    ra[c][rt[c]] = a;
    rt[c]++;
  endfunction

  function automatic bit pending();
    for (int c = 0; c < NC; c++)
      if (wh[c] < wt[c] || rh[c] < rt[c]) return 1'b1;
    return 1'b0;
  endfunction

  // Reference model: whole batch resolved up front; round-robin over channels
  // with pending work, a channel's write ahead of its read, 3 cycles per service.
  task automatic plan();
    int h_w [NC];
    int h_r [NC];
    int c, k;
    bit any;
    exp_t e;
    logic [AW-1:0] a;
    for (int i = 0; i < NC; i++) begin h_w[i] = wh[i]; h_r[i] = rh[i]; end
    k = 0;
    forever begin
      any = 1'b0;
      c = 0;
      for (int j = 0; j < NC; j++) begin
        if (!any && (h_w[(m_ptr + j) % NC] < wt[(m_ptr + j) % NC] ||
                     h_r[(m_ptr + j) % NC] < rt[(m_ptr + j) % NC])) begin
          any = 1'b1;
          c = (m_ptr + j) % NC;
        end
      end
      if (!any) break;
      e.chan = c;
      e.cyc  = cyc + 2 + 3 * k;
      if (h_w[c] < wt[c]) begin
        a = wa[c][h_w[c]];
        if (oob(a)) m_err = 1'b1;
        else        mm[int'(a) % MD] = wd[c][h_w[c]];
        e.is_wr = 1'b1;
        e.data  = '0;
        h_w[c]++;
      end else begin
        a = ra[c][h_r[c]];
        e.is_wr = 1'b0;
        if (oob(a)) begin m_err = 1'b1; e.data = '0; end
        else        e.data = mm[int'(a) % MD];
        last_rd[c] = e.data;
        h_r[c]++;
      end
      exp_q.push_back(e);
      m_ptr = (c + 1) % NC;
      k++;
    end
  endtask

  task automatic present();
    for (int c = 0; c < NC; c++) begin
      mem_write_valid[c] = (wh[c] < wt[c]);
      mem_read_valid[c]  = (rh[c] < rt[c]);
      mem_write_address[c*AW +: AW] = (wh[c] < wt[c]) ? wa[c][wh[c]] : '0;
      mem_write_data[c*DW +: DW]    = (wh[c] < wt[c]) ? wd[c][wh[c]] : '0;
      mem_read_address[c*AW +: AW]  = (rh[c] < rt[c]) ? ra[c][rh[c]] : '0;
    end
  endtask

  task automatic run_batch();
    int budget;
    @(negedge clk);
    plan();
    present();
    budget = 0;
    while (pending() && budget < 3000) begin
      @(negedge clk);
      budget++;
      for (int c = 0; c < NC; c++) begin
        if (mem_write_ready[c]) wh[c]++;
        if (mem_read_ready[c])  rh[c]++;
      end
      present();
    end
    if (pending()) begin
      check("batch_timeout", 1, 0);
      for (int c = 0; c < NC; c++) begin wh[c] = wt[c]; rh[c] = rt[c]; end
      present();
    end
    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    exp_q.delete();
    check("busy_idle", busy, 0);
    check("addr_error", addr_error, m_err);
    for (int c = 0; c < NC; c++) check("rdata_hold", mem_read_data[c*DW +: DW], last_rd[c]);
    for (int c = 0; c < NC; c++) begin wh[c] = 0; wt[c] = 0; rh[c] = 0; rt[c] = 0; end
  endtask

  task automatic model_reset();
    m_ptr = 0;
    m_err = 1'b0;
    for (int c = 0; c < NC; c++) last_rd[c] = '0;
  endtask

  task automatic check_reset_values();
    check("rst_read_ready", mem_read_ready, 0);
    check("rst_write_ready", mem_write_ready, 0);
    check("rst_read_data", mem_read_data, 0);
    check("rst_busy", busy, 0);
    check("rst_addr_error", addr_error, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int c = 0; c < NC; c++) begin wh[c] = 0; wt[c] = 0; rh[c] = 0; rt[c] = 0; end
    model_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_reset_values();

    // Fill every word so later reads are fully defined.
    for (int c = 0; c < NC; c++)
      for (int i = 0; i < MD / NC; i++) add_wr(c, AW'(c * (MD / NC) + i), $urandom);
    run_batch();

    add_wr(0, 8'h10, 32'hDEADBEEF);
    run_batch();
    add_rd(0, 8'h10);
    run_batch();

    for (int c = 0; c < NC; c++) add_wr(c, AW'(c), 32'h100 + DW'(c));
    run_batch();
    for (int c = 0; c < NC; c++) add_rd(c, AW'(c));
    run_batch();

    for (int i = 0; i < 4; i++) begin
      add_rd(1, AW'($urandom_range(0, MD - 1)));
      add_rd(3, AW'($urandom_range(0, MD - 1)));
    end
    run_batch();

    add_wr(0, 8'h30, 32'h12345678);
    add_rd(0, 8'h30);
    add_rd(2, 8'h30);
    run_batch();

    add_wr(1, 8'h40, 32'hCAFEF00D);
    run_batch();
    add_rd(0, 8'hC0);
    run_batch();

    for (int b = 0; b < 30; b++) begin
      for (int c = 0; c < NC; c++) begin
        for (int i = 0; i < int'($urandom_range(0, 3)); i++) add_wr(c, AW'($urandom), $urandom);
        for (int i = 0; i < int'($urandom_range(0, 3)); i++) add_rd(c, AW'($urandom));
      end
      run_batch();
    end

    // Reset while a ch2 write is in ACCESS: no commit, no ready.
    add_wr(0, 8'h20, 32'h11);
    run_batch();
    @(negedge clk);
    mem_write_valid[2] = 1'b1;
    mem_write_address[2*AW +: AW] = 8'h20;
    mem_write_data[2*DW +: DW] = 32'h55;
    @(posedge clk);
    #1;
    check("busy_in_access", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    check("busy_after_reset", busy, 0);
    mem_write_valid = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
    check_reset_values();
    add_rd(0, 8'h20);
    run_batch();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
